// File: rtl/sp_ram_fifo_pkg.sv
// Shared constants and grant encoding for the single-port-RAM FIFO controller.
package sp_ram_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 4;

    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

endpackage

// File: rtl/sp_ram_fifo_arb.sv
// Two-way round-robin arbiter for the single RAM port: a lone requester always wins,
// and on contention the side that did not win the previous contention gets the port.
module sp_ram_fifo_arb
    import sp_ram_fifo_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic wr_elig,
    input  logic rd_elig,
    output logic grant_wr,
    output logic grant_rd
);

    grant_e last_grant;
    logic   contended;

    assign contended = wr_elig & rd_elig;

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (contended) begin
            if (last_grant == GRANT_RD) begin
                grant_wr = 1'b1;
            end else begin
                grant_rd = 1'b1;
            end
        end else begin
            grant_wr = wr_elig;
            grant_rd = rd_elig;
        end
    end

    // History only moves on contended cycles, so uncontended traffic never skews fairness.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= GRANT_RD;
        end else if (contended) begin
            last_grant <= grant_wr ? GRANT_WR : GRANT_RD;
        end
    end

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller in front of a single-port registered-read RAM, with a valid/ready
// write port, a registered valid/ready read port and one RAM access per cycle.
module sp_ram_fifo_ctrl
    import sp_ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic                  rd_pending;
    logic                  out_valid;
    logic                  wr_elig;
    logic                  rd_elig;
    logic                  grant_wr;
    logic                  grant_rd;

    // Gating with rst_n keeps the write port closed while reset is held.
    assign wr_elig = rst_n & wr_valid & (ram_cnt != DEPTH_CNT);
    assign rd_elig = (ram_cnt != '0) & ~rd_pending & (~out_valid | rd_ready);

    sp_ram_fifo_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_elig  (wr_elig),
        .rd_elig  (rd_elig),
        .grant_wr (grant_wr),
        .grant_rd (grant_rd)
    );

    assign wr_ready    = grant_wr;
    assign ram_we      = grant_wr;
    assign ram_addr    = grant_wr ? wr_ptr : rd_ptr;
    assign ram_data_in = wr_data;

    assign rd_valid = out_valid;
    assign level    = ram_cnt + (ADDR_WIDTH+1)'(rd_pending) + (ADDR_WIDTH+1)'(out_valid);
    assign full     = (ram_cnt == DEPTH_CNT);
    assign empty    = (level == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            rd_pending <= 1'b0;
        end else begin
            if (grant_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (grant_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({grant_wr, grant_rd})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ram_cnt <= ram_cnt;
            endcase
            rd_pending <= grant_rd;
        end
    end

    // A read is only issued when the output register will be free on capture,
    // so capture and consume never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            rd_data   <= '0;
        end else if (rd_pending) begin
            out_valid <= 1'b1;
            rd_data   <= ram_data_out;
        end else if (out_valid && rd_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Self-checking bench: behavioural RAM, queue-based reference model, a directed vector
// table, hand-written corner sequences and randomized streaming.
module tb_sp_ram_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_ready;
    logic [4:0] level;
    logic       full;
    logic       empty;
    logic [3:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out;

    int checks = 0;
    int errors = 0;

    sp_ram_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_ready     (rd_ready),
        .level        (level),
        .full         (full),
        .empty        (empty),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16 x 8 single-port RAM with registered read
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data_in;
        ram_data_out <= mem[ram_addr];
    end

    // Reference model: words held as queues, pointers as plain access counts
    logic [7:0] m_ram[$];
    logic       m_pend;
    logic [7:0] m_pend_word;
    logic       m_out;
    logic [7:0] m_out_word;
    logic       m_last_wr;
    int         m_wr_cnt;
    int         m_rd_cnt;
    logic [7:0] sb_in[$];

    logic       s_wr_ready, s_rd_valid, s_full, s_empty, s_accept;
    logic [7:0] s_rd_data;
    int         s_level;

    function automatic int model_level();
        return m_ram.size() + int'(m_pend) + int'(m_out);
    endfunction

    task automatic model_reset();
        m_ram.delete();
        sb_in.delete();
        m_pend = 1'b0;
        m_pend_word = 8'h00;
        m_out = 1'b0;
        m_out_word = 8'h00;
        m_last_wr = 1'b0;
        m_wr_cnt = 0;
        m_rd_cnt = 0;
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic wv, input logic [7:0] wd, input logic rr);
        logic we_e, re_e, gw, gr;
        int   exp_addr;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        @(negedge clk);
        we_e = wv && (m_ram.size() != 16);
        re_e = (m_ram.size() != 0) && !m_pend && (!m_out || rr);
        if (we_e && re_e) begin
            gw = !m_last_wr;
            gr = m_last_wr;
        end else begin
            gw = we_e;
            gr = re_e;
        end
        exp_addr = gw ? (m_wr_cnt % 16) : (m_rd_cnt % 16);
        s_wr_ready = wr_ready;
        s_rd_valid = rd_valid;
        s_rd_data  = rd_data;
        s_level    = int'(level);
        s_full     = full;
        s_empty    = empty;
        s_accept   = wv && wr_ready;
        check_output("wr_ready", int'(wr_ready), int'(gw));
        check_output("ram_we", int'(ram_we), int'(gw));
        check_output("ram_addr", int'(ram_addr), exp_addr);
        if (gw) check_output("ram_data_in", int'(ram_data_in), int'(wd));
        check_output("rd_valid", int'(rd_valid), int'(m_out));
        check_output("rd_data", int'(rd_data), int'(m_out_word));
        check_output("level", int'(level), model_level());
        check_output("full", int'(full), int'(m_ram.size() == 16));
        check_output("empty", int'(empty), int'(model_level() == 0));
        if (s_accept) sb_in.push_back(wd);
        if (rd_valid && rr) begin
            if (sb_in.size() == 0) check_output("order_underflow", 1, 0);
            else check_output("order", int'(rd_data), int'(sb_in.pop_front()));
        end
        if (m_pend) begin
            m_out_word = m_pend_word;
            m_out = 1'b1;
            m_pend = 1'b0;
        end else if (m_out && rr) begin
            m_out = 1'b0;
        end
        if (gr) begin
            m_pend_word = m_ram.pop_front();
            m_pend = 1'b1;
            m_rd_cnt++;
        end
        if (gw) begin
            m_ram.push_back(wd);
            m_wr_cnt++;
        end
        if (we_e && re_e) m_last_wr = gw;
        @(posedge clk);
        #1;
    endtask

    // Asserted mid-cycle so the asynchronous clear is observed before any clock edge.
    task automatic do_reset();
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        rd_ready = 1'b1;
        rst_n    = 1'b0;
        #1;
        check_output("rst_rd_valid", int'(rd_valid), 0);
        check_output("rst_rd_data", int'(rd_data), 0);
        check_output("rst_level", int'(level), 0);
        check_output("rst_ram_we", int'(ram_we), 0);
        check_output("rst_wr_ready", int'(wr_ready), 0);
        check_output("rst_ram_addr", int'(ram_addr), 0);
        check_output("rst_full", int'(full), 0);
        check_output("rst_empty", int'(empty), 1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        while (model_level() != 0 && guard < 200) begin
            apply_stimulus(1'b0, 8'h00, 1'b1);
            guard++;
        end
        if (guard >= 200) check_output("drain_timeout", 1, 0);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("drain_empty", int'(s_empty), 1);
        check_output("drain_level", s_level, 0);
    endtask

    typedef struct {
        logic       wr_valid;
        logic [7:0] wr_data;
        logic       rd_ready;
        logic       exp_wr_ready;
        logic       exp_rd_valid;
        logic [7:0] exp_rd_data;
        int         exp_level;
    } vec_t;

    vec_t vecs[11];

    initial begin
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        rd_ready = 1'b0;

        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        vecs[1]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00, 1};
        vecs[2]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 2};
        vecs[3]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 2};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 3};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 3};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 2};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 2};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hFF, 1};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hFF, 0};

        do_reset();

        // Back-to-back writes then drain, including the first contention after reset.
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].wr_valid, vecs[i].wr_data, vecs[i].rd_ready);
            check_output($sformatf("vec%0d_wr_ready", i), int'(s_wr_ready), int'(vecs[i].exp_wr_ready));
            check_output($sformatf("vec%0d_rd_valid", i), int'(s_rd_valid), int'(vecs[i].exp_rd_valid));
            check_output($sformatf("vec%0d_rd_data", i), int'(s_rd_data), int'(vecs[i].exp_rd_data));
            check_output($sformatf("vec%0d_level", i), s_level, vecs[i].exp_level);
        end

        // Fill: 17 words 00..10 with the consumer stalled.
        for (int w = 0; w < 17; w++) begin
            int tries = 0;
            s_accept = 1'b0;
            while (!s_accept && tries < 50) begin
                apply_stimulus(1'b1, 8'(w), 1'b0);
                tries++;
            end
            if (!s_accept) check_output("fill_timeout", 0, 1);
        end
        repeat (3) apply_stimulus(1'b1, 8'h11, 1'b0);
        check_output("full_level", s_level, 17);
        check_output("full_flag", int'(s_full), 1);
        check_output("full_wr_ready", int'(s_wr_ready), 0);
        check_output("full_head", int'(s_rd_data), 0);
        drain();

        // Sustained contention from reset: grants alternate, nothing lost.
        do_reset();
        for (int i = 0; i < 40; i++) apply_stimulus(1'b1, 8'(8'h40 + i), 1'b1);
        drain();

        // Randomized streaming with stalls on both sides; pointers wrap many times.
        begin
            int accepted = 0;
            for (int c = 0; c < 600; c++) begin
                apply_stimulus($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 55);
                if (s_accept) accepted++;
            end
            check_output("wrap_accepted_ge_40", int'(accepted >= 40), 1);
            drain();
        end

        // Reset one cycle after a read issue, with a stale word in the output register.
        do_reset();
        apply_stimulus(1'b1, 8'h5A, 1'b0);
        repeat (3) apply_stimulus(1'b0, 8'h00, 1'b0);
        check_output("pre_rst_rd_data", int'(s_rd_data), 8'h5A);
        apply_stimulus(1'b1, 8'hC3, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        do_reset();
        repeat (4) apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("post_rst_rd_valid", int'(s_rd_valid), 0);
        check_output("post_rst_rd_data", int'(s_rd_data), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
